// File: rtl/freq_meas_ctrl_if.sv
// Control, capture-unit and result-handshake signals of freq_meas_ctrl.
// The master side drives requests and capture data; the slave is the controller.
interface freq_meas_ctrl_if;
    logic        start;
    logic        abort;
    logic [2:0]  avg_log2;
    logic        cap_done;
    logic [31:0] cap_period;
    logic [31:0] cap_high;
    logic        cap_clr;
    logic        busy;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_period;
    logic [31:0] res_high;
    logic        res_timeout;

    modport master (
        output start, abort, avg_log2, cap_done, cap_period, cap_high, res_ready,
        input  cap_clr, busy, res_valid, res_period, res_high, res_timeout
    );

    modport slave (
        input  start, abort, avg_log2, cap_done, cap_period, cap_high, res_ready,
        output cap_clr, busy, res_valid, res_period, res_high, res_timeout
    );
endinterface

// File: rtl/freq_meas_ctrl.sv
// Frequency measurement controller: restarts the capture unit, drops the first
// (partial) period, averages 2^N captured periods/high times and hands the
// result over with a valid/ready handshake. A watchdog ends the measurement
// with a timeout result if the capture unit goes quiet.
module freq_meas_ctrl #(
    parameter int unsigned CLOCK_FREQ     = 50000000,
    parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
    input  logic           clk,
    input  logic           rst,
    freq_meas_ctrl_if.slave bus
);
    // A zero timeout would never let a measurement end; fall back to one second.
    localparam int unsigned TMO_CYC  = (TIMEOUT_CYCLES != 0) ? TIMEOUT_CYCLES : CLOCK_FREQ;
    localparam logic [31:0] TMO_LAST = 32'(TMO_CYC - 1);

    typedef enum logic [2:0] {S_IDLE, S_ARM, S_DISCARD, S_ACCUM, S_DONE} state_t;

    state_t      r_state;
    logic        r_cap_clr;
    logic        r_busy;
    logic        r_res_valid;
    logic        r_res_timeout;
    logic [31:0] r_res_period;
    logic [31:0] r_res_high;
    logic [35:0] r_pacc;
    logic [35:0] r_hacc;
    logic [4:0]  r_cnt;
    logic [31:0] r_timer;
    logic [2:0]  r_avg;

    logic [35:0] w_pacc_nxt;
    logic [35:0] w_hacc_nxt;
    logic [4:0]  w_cnt_nxt;
    logic        w_last;
    logic        w_expire;
    logic [2:0]  w_avg_clamp;
    logic [31:0] w_pres;
    logic [31:0] w_hres;

    // 16 samples of 0xFFFFFFFF need 36 bits; the shifted average always fits 32.
    assign w_pacc_nxt  = r_pacc + {4'd0, bus.cap_period};
    assign w_hacc_nxt  = r_hacc + {4'd0, bus.cap_high};
    assign w_cnt_nxt   = r_cnt + 5'd1;
    assign w_last      = (w_cnt_nxt == (5'd1 << r_avg));
    assign w_expire    = (r_timer == TMO_LAST);
    assign w_avg_clamp = (bus.avg_log2 > 3'd4) ? 3'd4 : bus.avg_log2;
    assign w_pres      = 32'(w_pacc_nxt >> r_avg);
    assign w_hres      = 32'(w_hacc_nxt >> r_avg);

    assign bus.cap_clr     = r_cap_clr;
    assign bus.busy        = r_busy;
    assign bus.res_valid   = r_res_valid;
    assign bus.res_timeout = r_res_timeout;
    assign bus.res_period  = r_res_period;
    assign bus.res_high    = r_res_high;

    // Measurement FSM; every output is a register updated alongside the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_cap_clr     <= 1'b0;
            r_busy        <= 1'b0;
            r_res_valid   <= 1'b0;
            r_res_timeout <= 1'b0;
            r_res_period  <= '0;
            r_res_high    <= '0;
            r_pacc        <= '0;
            r_hacc        <= '0;
            r_cnt         <= '0;
            r_timer       <= '0;
            r_avg         <= '0;
        end else if (bus.abort) begin
            // Abort wins over everything; the last result data is kept.
            r_state       <= S_IDLE;
            r_cap_clr     <= 1'b0;
            r_busy        <= 1'b0;
            r_res_valid   <= 1'b0;
            r_res_timeout <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state       <= S_ARM;
                        r_avg         <= w_avg_clamp;
                        r_pacc        <= '0;
                        r_hacc        <= '0;
                        r_cnt         <= '0;
                        r_timer       <= '0;
                        r_cap_clr     <= 1'b1;
                        r_busy        <= 1'b1;
                        r_res_timeout <= 1'b0;
                    end
                end
                S_ARM: begin
                    r_cap_clr <= 1'b0;
                    r_state   <= S_DISCARD;
                end
                S_DISCARD: begin
                    if (bus.cap_done) begin
                        r_timer <= '0;
                        r_state <= S_ACCUM;
                    end else if (w_expire) begin
                        r_state       <= S_DONE;
                        r_res_valid   <= 1'b1;
                        r_res_timeout <= 1'b1;
                        r_res_period  <= '0;
                        r_res_high    <= '0;
                    end else begin
                        r_timer <= r_timer + 32'd1;
                    end
                end
                S_ACCUM: begin
                    // A sample arriving on the expiry cycle still counts.
                    if (bus.cap_done) begin
                        r_timer <= '0;
                        r_pacc  <= w_pacc_nxt;
                        r_hacc  <= w_hacc_nxt;
                        r_cnt   <= w_cnt_nxt;
                        if (w_last) begin
                            r_state      <= S_DONE;
                            r_res_valid  <= 1'b1;
                            r_res_period <= w_pres;
                            r_res_high   <= w_hres;
                        end
                    end else if (w_expire) begin
                        r_state       <= S_DONE;
                        r_res_valid   <= 1'b1;
                        r_res_timeout <= 1'b1;
                        r_res_period  <= '0;
                        r_res_high    <= '0;
                    end else begin
                        r_timer <= r_timer + 32'd1;
                    end
                end
                S_DONE: begin
                    // Start is not looked at here, so it is dropped even on the handshake cycle.
                    if (bus.res_ready) begin
                        r_state     <= S_IDLE;
                        r_res_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
